// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multdiv sequencer states, exception codes and
// register indices / ALU opcodes used by the decoder and execute stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_LAUNCH,
    MD_WAIT,
    MD_WB
  } md_state_e;

  localparam int unsigned MULT_EXC_CODE = 4;
  localparam int unsigned DIV_EXC_CODE  = 5;

  localparam int unsigned RSTATUS_REG = 30;
  localparam int unsigned RA_REG      = 31;

  localparam logic [3:0] ALUOP_MULT = 4'd6;
  localparam logic [3:0] ALUOP_DIV  = 4'd7;

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter bounding how long the sequencer waits on the multdiv unit.
module md_watchdog #(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntW'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared iterative mult/div unit: latches an
// instruction, pulses the unit, stalls the pipe and issues a single writeback.
module multdiv_sequencer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_CYCLES    = 40,
  parameter int unsigned MULT_EXC_CODE = cpu_pkg::MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE  = cpu_pkg::DIV_EXC_CODE,
  parameter int unsigned RSTATUS_REG   = cpu_pkg::RSTATUS_REG
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic              is_mult,
  input  logic              is_div,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_op_a,
  output logic [DATA_W-1:0] md_op_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  import cpu_pkg::*;

  md_state_e         state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, wb_data_q, wb_data_d;
  logic [4:0]        rd_q, rd_d, wb_reg_q, wb_reg_d;
  logic              is_div_q, is_div_d;
  logic              accept, wd_clear, wd_enable, wd_expired;

  md_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  // reset_n gates the only input-to-stall path so stall drops the instant reset asserts.
  assign accept = reset_n && (state_q == MD_IDLE) && issue_valid && (is_mult ^ is_div) && !flush;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    stall     = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        stall = accept;
        if (accept) begin
          op_a_d   = op_a;
          op_b_d   = op_b;
          rd_d     = rd;
          is_div_d = is_div;
          state_d  = MD_LAUNCH;
        end
      end
      MD_LAUNCH: begin
        stall    = 1'b1;
        wd_clear = 1'b1;
        state_d  = flush ? MD_IDLE : MD_WAIT;
      end
      MD_WAIT: begin
        stall     = 1'b1;
        wd_enable = 1'b1;
        if (flush) begin
          state_d = MD_IDLE;
        end else if (md_ready || wd_expired) begin
          if (md_ready && !md_exception) begin
            wb_reg_d  = rd_q;
            wb_data_d = md_result;
          end else begin
            wb_reg_d  = 5'(RSTATUS_REG);
            wb_data_d = is_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
          end
          state_d = MD_WB;
        end
      end
      MD_WB: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MD_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign md_ctrl_mult = (state_q == MD_LAUNCH) && !is_div_q;
  assign md_ctrl_div  = (state_q == MD_LAUNCH) && is_div_q;
  assign md_op_a      = op_a_q;
  assign md_op_b      = op_b_q;
  assign wb_valid     = (state_q == MD_WB);
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomised scoreboard bench for multdiv_sequencer; the bench plays the multdiv unit.
module tb_multdiv_sequencer;

  localparam int MAXC = 40;

  logic        clock, reset_n;
  logic        issue_valid, is_mult, is_div, flush;
  logic [4:0]  rd;
  logic [31:0] op_a, op_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_op_a, md_op_b, md_result;
  logic        md_exception, md_ready;
  logic        stall, wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;
  wb_t exp_q[$];

  multdiv_sequencer #(
    .DATA_W    (32),
    .MAX_CYCLES(MAXC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .is_mult     (is_mult),
    .is_div      (is_div),
    .rd          (rd),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div (md_ctrl_div),
    .md_op_a     (md_op_a),
    .md_op_b     (md_op_b),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_ready    (md_ready),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest expected writeback.
  always @(negedge clock) begin
    if (reset_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wb: got reg=%0d data=%0h expected none", wb_reg, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_reg", 64'(wb_reg), 64'(e.r));
        chk("wb_data", 64'(wb_data), 64'(e.d));
      end
    end
  end

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    is_mult      = 1'b0;
    is_div       = 1'b0;
    flush        = 1'b0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
  endtask

  // One instruction. k: ready delay after the pulse (0 or >MAXC => never);
  // f: flush in the f-th WAIT cycle (0 => none).
  task automatic do_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input int k, input bit exc, input int f);
    logic [31:0] res;
    bit          responds, timeout;
    int          scnt, exp_stall;
    wb_t         e;
    responds = (k >= 1) && (k <= MAXC) && !(f > 0 && f < k + 1);
    timeout  = !responds && (f == 0);
    res      = mul ? a * b : (b == 0 ? 32'h0 : a / b);
    if (f > 0) begin
      exp_stall = 2 + f;
    end else if (timeout) begin
      exp_stall = 2 + MAXC;
      e.r = 5'd30;
      e.d = mul ? 32'd4 : 32'd5;
      exp_q.push_back(e);
    end else begin
      exp_stall = 2 + k;
      e.r = exc ? 5'd30 : r;
      e.d = exc ? (mul ? 32'd4 : 32'd5) : res;
      exp_q.push_back(e);
    end

    @(posedge clock); #1;
    issue_valid = 1'b1; is_mult = mul; is_div = !mul; rd = r; op_a = a; op_b = b;
    scnt = 0;
    @(negedge clock);
    if (stall) scnt++;
    @(posedge clock); #1;
    issue_valid = 1'b0; op_a = $urandom; op_b = $urandom; rd = 5'($urandom);
    @(negedge clock);
    if (stall) scnt++;
    chk("pulse_mult", 64'(md_ctrl_mult), 64'(mul));
    chk("pulse_div", 64'(md_ctrl_div), 64'(!mul));
    chk("md_op_a", 64'(md_op_a), 64'(a));
    chk("md_op_b", 64'(md_op_b), 64'(b));
    for (int i = 1; i <= MAXC + 5; i++) begin
      @(posedge clock); #1;
      md_ready     = responds && (i == k);
      md_exception = md_ready && exc;
      md_result    = md_ready ? res : 32'($urandom);
      // flush during WRITEBACK must be ignored
      flush = (i == f) || (f == 0 && ((responds && i == k + 1) || (timeout && i == MAXC + 1))
                           && $urandom_range(0, 1) == 1);
      @(negedge clock);
      if (!stall) break;
      scnt++;
      chk("no_pulse_wait", 64'(md_ctrl_mult | md_ctrl_div), 64'd0);
      chk("op_a_stable", 64'(md_op_a), 64'(a));
    end
    chk("stall_cycles", 64'(scnt), 64'(exp_stall));
    chk("wb_at_release", 64'(wb_valid), 64'(f == 0));
    @(posedge clock); #1;
    idle_inputs();
    if (f > 0) begin
      // a late unit response after a flush must not produce a writeback
      md_ready = 1'b1; md_result = 32'hdead_beef;
      @(posedge clock); #1;
      md_ready = 1'b0;
      @(negedge clock);
      chk("stall_after_flush", 64'(stall), 64'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    rd = '0; op_a = '0; op_b = '0; md_result = '0;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_pulse", 64'(md_ctrl_mult | md_ctrl_div), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    do_op(1'b1, 32'd6, 32'd7, 5'd3, 16, 1'b0, 0);
    do_op(1'b0, 32'd10, 32'd0, 5'd5, 3, 1'b1, 0);
    do_op(1'b1, 32'hffff_ffff, 32'h7fff_ffff, 5'd9, 5, 1'b1, 0);
    do_op(1'b0, 32'd100, 32'd7, 5'd4, 0, 1'b0, 0);
    do_op(1'b1, 32'd8, 32'd8, 5'd6, 0, 1'b0, 4);
    do_op(1'b1, 32'd3, 32'd3, 5'd2, 2, 1'b0, 0);
    do_op(1'b0, 32'd77, 32'd7, 5'd0, 1, 1'b0, 0);
    do_op(1'b1, 32'd5, 32'd5, 5'd1, MAXC, 1'b0, 0);

    // illegal decode: both opcodes set
    @(posedge clock); #1;
    issue_valid = 1'b1; is_mult = 1'b1; is_div = 1'b1; rd = 5'd7;
    @(negedge clock);
    chk("illegal_stall", 64'(stall), 64'd0);
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    chk("illegal_pulse", 64'(md_ctrl_mult | md_ctrl_div), 64'd0);
    chk("illegal_stall2", 64'(stall), 64'd0);

    // asynchronous reset mid-WAIT
    @(posedge clock); #1;
    issue_valid = 1'b1; is_mult = 1'b0; is_div = 1'b1; op_a = 32'd50; op_b = 32'd5; rd = 5'd8;
    @(posedge clock); #1;
    idle_inputs();
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_op_a", 64'(md_op_a), 64'd0);
    chk("arst_wb_reg", 64'(wb_reg), 64'd0);
    chk("arst_wb_data", 64'(wb_data), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_rst_pulse", 64'(md_ctrl_mult | md_ctrl_div | stall), 64'd0);
    end

    for (int n = 0; n < 30; n++) begin
      bit          mul, exc;
      logic [31:0] a, b;
      int          k, f;
      mul = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      exc = (!mul && b == 0) || ($urandom_range(0, 7) == 0);
      k   = $urandom_range(1, MAXC + 4);
      f   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : 0;
      do_op(mul, a, b, 5'($urandom), k, exc, f);
    end

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Sequences the shared iterative multiplier/divider for the execute stage.
- Accepts a mult or div from the decoded instruction stream and latches the operands and destination.
- Issues a one-cycle start pulse to the multdiv unit and stalls the pipeline until the result returns or a watchdog expires.
- Presents one writeback: the result to rd, or an exception code to rstatus.

Parameters:
- DATA_W, 32, operand/result width.
- MAX_CYCLES, 40, maximum WAIT cycles before a forced timeout exception.
- MULT_EXC_CODE, 4, value written to rstatus on a mult exception or timeout.
- DIV_EXC_CODE, 5, value written to rstatus on a div exception or timeout.
- RSTATUS_REG, 30, register index used for exception writeback.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  execute stage holds a valid instruction.
- is_mult  in  1  decoded mult (ALU opcode, ALUop 6).
- is_div  in  1  decoded div (ALU opcode, ALUop 7).
- rd  in  5  destination register of the instruction.
- op_a  in  DATA_W  rs value.
- op_b  in  DATA_W  rt value.
- flush  in  1  squash the in-flight instruction (branch/jump redirect).
- md_ctrl_mult  out  1  one-cycle start pulse, multiply.
- md_ctrl_div  out  1  one-cycle start pulse, divide.
- md_op_a  out  DATA_W  latched operand A, held stable from LAUNCH through WAIT.
- md_op_b  out  DATA_W  latched operand B, held stable from LAUNCH through WAIT.
- md_result  in  DATA_W  unit result.
- md_exception  in  1  unit overflow/divide-by-zero, valid with md_ready.
- md_ready  in  1  unit result valid (single-cycle pulse).
- stall  out  1  freeze PC and upstream pipeline registers.
- wb_valid  out  1  writeback strobe, one cycle.
- wb_reg  out  5  writeback destination.
- wb_data  out  DATA_W  writeback value.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; counter, latched operands, rd and op all cleared.
  - All outputs are 0 immediately, including stall.
- accept = state==IDLE & issue_valid & (is_mult XOR is_div) & !flush.
  - is_mult & is_div together is illegal: not accepted, no pulse, no stall.
- States: IDLE, LAUNCH, WAIT, WRITEBACK.
- IDLE:
  - On accept: latch op_a, op_b, rd and op type; go to LAUNCH.
  - stall = accept. This is the only combinational path from inputs to stall, so the pipeline freezes in the accept cycle.
- LAUNCH:
  - md_ctrl_mult or md_ctrl_div is 1 for exactly this cycle; stall=1; counter cleared.
  - md_ready is ignored in this cycle.
  - Next state is WAIT, or IDLE if flush.
- WAIT:
  - stall=1; counter increments each cycle.
  - Priority: flush > md_ready > timeout.
  - flush: go to IDLE with no writeback; any later md_ready is ignored.
  - md_ready: capture the writeback and go to WRITEBACK.
    - md_exception=0: wb_reg=latched rd, wb_data=md_result.
    - md_exception=1: wb_reg=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE according to op.
  - Timeout: counter==MAX_CYCLES-1 with no md_ready; capture the exception writeback as above and go to WRITEBACK.
- WRITEBACK:
  - wb_valid=1 for one cycle; stall=0, so the pipeline advances.
  - Next state is IDLE unconditionally; the instruction still in the stage this cycle is never re-accepted.
  - flush in this cycle is ignored, because the instruction has already completed.
- Outside WRITEBACK: wb_valid=0; wb_reg and wb_data hold their last captured values.
- rd==0 with no exception: wb_valid is still asserted with wb_reg=0; the register file discards the write.
- Latency:
  - Accept at cycle T, start pulse at T+1.
  - md_ready at T+1+k (k>=1) gives wb_valid at T+2+k.
  - Total stall is 2+k cycles.
- Flush after LAUNCH: the unit is abandoned mid-operation. The next start pulse restarts it; the unit's contract is that ctrl restarts it.
- Back-to-back mult/div: the earliest second accept is the cycle after WRITEBACK.

Decomposition:
- Shared package (cpu_pkg):
  - State enum MD_IDLE/MD_LAUNCH/MD_WAIT/MD_WB.
  - Exception codes MULT_EXC_CODE and DIV_EXC_CODE.
  - RSTATUS_REG=30, RA_REG=31, and the ALUop encodings MULT=6, DIV=7 shared with the decoder.
- Sub-module md_watchdog: cycle counter with clear/enable/expired ports, parameterised by MAX_CYCLES.

Test Plan:
- Mult 6*7, rd=3, md_ready 16 cycles after the pulse:
  - Exactly one md_ctrl_mult pulse; md_op_a=6, md_op_b=7.
  - stall high for 18 cycles.
  - wb_valid=1 for one cycle with wb_reg=3, wb_data=42.
- Div 10/0, rd=5, md_ready+md_exception after 3 cycles -> wb_reg=30, wb_data=5, rd 5 untouched.
- Mult overflow exception -> wb_reg=30, wb_data=4.
- Div with md_ready never asserted -> after 40 WAIT cycles, wb_valid with wb_reg=30, wb_data=5; stall then drops.
- Flush asserted 4 cycles into WAIT:
  - Back to IDLE, stall=0 next cycle, no wb_valid.
  - A later md_ready is ignored.
  - A following mult 3*3, rd=2, completes with wb_data=9.
- Reset and illegal decode:
  - reset_n pulled low mid-WAIT -> stall and all outputs 0 without a clock edge; after release, IDLE with no spurious md_ctrl pulse.
  - is_mult=is_div=1 -> no accept.
